// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache/memory interconnect: the Wishbone
// arbiter state encoding and an index-width helper for port vectors.
package lc3b_types;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner picker: round-robin starting just after the last-grant
// pointer, or fixed priority where the lowest requesting index wins.
module wb_arb_pick
    import lc3b_types::*;
#(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = arb_idx_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    input  logic               rr_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               vld_o
);

    logic [IDX_W-1:0] cand;

    // Scan candidates in search order; the first requester found wins.
    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = IDX_W'(rr_i ? (int'(last_i) + 1 + k) % N_PORTS : k);
            if (!vld_o && req_i[cand]) begin
                win_o = cand;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to one-slave classic Wishbone arbiter with a registered grant.
// Define WB_ARB_TIMEOUT_EN to add a slave-timeout watchdog that retries the master.
module wb_arbiter_n
    import lc3b_types::*;
#(
    parameter int N_PORTS     = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 128,
    parameter int SEL_W       = 16,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        m_cyc,
    input  logic [N_PORTS-1:0]        m_stb,
    input  logic [N_PORTS-1:0]        m_we,
    input  logic [N_PORTS*ADDR_W-1:0] m_adr,
    input  logic [N_PORTS*DATA_W-1:0] m_dat_m,
    input  logic [N_PORTS*SEL_W-1:0]  m_sel,
    output logic [N_PORTS-1:0]        m_ack,
    output logic [N_PORTS-1:0]        m_rty,
    output logic [DATA_W-1:0]         m_dat_s,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_adr,
    output logic [DATA_W-1:0]         s_dat_m,
    output logic [SEL_W-1:0]          s_sel,
    input  logic                      s_ack,
    input  logic                      s_rty,
    input  logic [DATA_W-1:0]         s_dat_s
);

    localparam int               IDX_W    = arb_idx_w(N_PORTS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [N_PORTS-1:0] req;
    logic [IDX_W-1:0]  win;
    logic              win_vld;
    logic              busy;
    logic              tmo;
    logic              g_cyc, g_stb, g_we;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;
    logic [SEL_W-1:0]  g_sel;

    assign req  = m_cyc & m_stb;
    assign busy = (state_q == ARB_BUSY);

    wb_arb_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .rr_i   (ROUND_ROBIN != 0),
        .win_o  (win),
        .vld_o  (win_vld)
    );

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                g_cyc = m_cyc[i];
                g_stb = m_stb[i];
                g_we  = m_we[i];
                g_adr = m_adr[i*ADDR_W +: ADDR_W];
                g_dat = m_dat_m[i*DATA_W +: DATA_W];
                g_sel = m_sel[i*SEL_W +: SEL_W];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter sits at zero in IDLE, so every BUSY entry starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!s_ack && !s_rty) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo = busy && !s_ack && !s_rty && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    state_d = ARB_BUSY;
                    grant_d = win;
                end
            end
            ARB_BUSY: begin
                if (s_ack || s_rty || !g_cyc || tmo) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Slave side follows the granted master combinationally so an abort drops CYC at once.
    assign s_cyc   = busy & g_cyc;
    assign s_stb   = busy & g_cyc & g_stb;
    assign s_we    = busy & g_we;
    assign s_adr   = busy ? g_adr : '0;
    assign s_dat_m = busy ? g_dat : '0;
    assign s_sel   = busy ? g_sel : '0;
    assign m_dat_s = s_dat_s;

    always_comb begin
        m_ack = '0;
        m_rty = '0;
        if (busy) begin
            m_ack[grant_q] = s_ack;
            m_rty[grant_q] = (s_rty & ~s_ack) | tmo;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: a round-robin and a fixed-priority instance share stimulus.
// Honours WB_ARB_TIMEOUT_EN for the watchdog sequence and the reference model.
module tb_wb_arbiter_n;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 128;
    localparam int SW = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    m_cyc, m_stb, m_we;
    logic [NP*AW-1:0] m_adr;
    logic [NP*DW-1:0] m_dat_m;
    logic [NP*SW-1:0] m_sel;
    logic             s_ack, s_rty;
    logic [DW-1:0]    s_dat_s;

    logic [NP-1:0]    m_ack_w [2];
    logic [NP-1:0]    m_rty_w [2];
    logic [DW-1:0]    m_dats_w[2];
    logic             s_cyc_w [2];
    logic             s_stb_w [2];
    logic             s_we_w  [2];
    logic [AW-1:0]    s_adr_w [2];
    logic [DW-1:0]    s_datm_w[2];
    logic [SW-1:0]    s_sel_w [2];

    int ncmp = 0;
    int nerr = 0;

    logic [AW-1:0] adr_tab[NP] = '{12'h100, 12'h040, 12'h200, 12'h300};
    logic [DW-1:0] beef = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

    always #5 clk = ~clk;

    wb_arbiter_n #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
                   .ROUND_ROBIN(1), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel), .m_ack(m_ack_w[0]),
        .m_rty(m_rty_w[0]), .m_dat_s(m_dats_w[0]), .s_cyc(s_cyc_w[0]), .s_stb(s_stb_w[0]),
        .s_we(s_we_w[0]), .s_adr(s_adr_w[0]), .s_dat_m(s_datm_w[0]), .s_sel(s_sel_w[0]),
        .s_ack(s_ack), .s_rty(s_rty), .s_dat_s(s_dat_s));

    wb_arbiter_n #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
                   .ROUND_ROBIN(0), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel), .m_ack(m_ack_w[1]),
        .m_rty(m_rty_w[1]), .m_dat_s(m_dats_w[1]), .s_cyc(s_cyc_w[1]), .s_stb(s_stb_w[1]),
        .s_we(s_we_w[1]), .s_adr(s_adr_w[1]), .s_dat_m(s_datm_w[1]), .s_sel(s_sel_w[1]),
        .s_ack(s_ack), .s_rty(s_rty), .s_dat_s(s_dat_s));

    typedef struct {
        logic          rst;
        logic [NP-1:0] cyc;
        logic          ack;
        logic          rty;
        logic          ecyc;
        int            g_rr;
        int            g_fp;
        logic          eack;
        logic          erty;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic [NP-1:0] cyc, input logic ack,
                       input logic rty, input logic ecyc, input int g_rr, input int g_fp,
                       input logic eack, input logic erty);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.rty = rty; v.ecyc = ecyc;
        v.g_rr = g_rr; v.g_fp = g_fp; v.eack = eack; v.erty = erty;
        vt.push_back(v);
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_fixed();
        for (int i = 0; i < NP; i++) begin
            m_adr[i*AW +: AW]   = adr_tab[i];
            m_dat_m[i*DW +: DW] = {4{32'hA000_0000 + 32'(i)}};
        end
        m_sel   = '1;
        m_we    = '0;
        s_dat_s = beef;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: per instance (0 = round-robin, 1 = fixed priority).
    int mbusy[2], mown[2], mlast[2], mwait[2];

    function automatic int pick(input int d, input logic [NP-1:0] req, input int lst);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (d == 0) ? (lst + 1 + k) % NP : k;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 0; mown[d] = 0; mlast[d] = NP - 1; mwait[d] = 0;
        end
    endtask

    task automatic model_check_step(input int n);
        for (int d = 0; d < 2; d++) begin
            int o, w;
            logic b, tmo;
            logic [NP-1:0] eack, erty;
            o = mown[d];
            b = (mbusy[d] != 0);
            tmo = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo = b && !s_ack && !s_rty && (mwait[d] == TO - 1);
`endif
            eack = (b && s_ack) ? NP'(1 << o) : '0;
            erty = (b && ((s_rty && !s_ack) || tmo)) ? NP'(1 << o) : '0;
            check($sformatf("rnd%0d.%0d s_cyc", n, d), s_cyc_w[d], b && m_cyc[o]);
            check($sformatf("rnd%0d.%0d s_stb", n, d), s_stb_w[d], b && m_cyc[o] && m_stb[o]);
            check($sformatf("rnd%0d.%0d m_ack", n, d), m_ack_w[d], eack);
            check($sformatf("rnd%0d.%0d m_rty", n, d), m_rty_w[d], erty);
            check($sformatf("rnd%0d.%0d m_dat_s", n, d), m_dats_w[d], s_dat_s);
            if (b) begin
                check($sformatf("rnd%0d.%0d s_adr", n, d), s_adr_w[d], m_adr[o*AW +: AW]);
                check($sformatf("rnd%0d.%0d s_we", n, d), s_we_w[d], m_we[o]);
                check($sformatf("rnd%0d.%0d s_sel", n, d), s_sel_w[d], m_sel[o*SW +: SW]);
                check($sformatf("rnd%0d.%0d s_dat_m", n, d), s_datm_w[d], m_dat_m[o*DW +: DW]);
                if (s_ack || s_rty || !m_cyc[o] || tmo) begin
                    mbusy[d] = 0;
                    mlast[d] = o;
                end else begin
                    mwait[d]++;
                end
            end else begin
                w = pick(d, m_cyc & m_stb, mlast[d]);
                if (w >= 0) begin
                    mbusy[d] = 1; mown[d] = w; mwait[d] = 0;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_rty = 1'b0;
        set_fixed();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst.%0d s_cyc", d), s_cyc_w[d], 1'b0);
            check($sformatf("rst.%0d s_stb", d), s_stb_w[d], 1'b0);
            check($sformatf("rst.%0d s_adr", d), s_adr_w[d], '0);
            check($sformatf("rst.%0d s_sel", d), s_sel_w[d], '0);
            check($sformatf("rst.%0d m_ack", d), m_ack_w[d], '0);
            check($sformatf("rst.%0d m_rty", d), m_rty_w[d], '0);
            check($sformatf("rst.%0d m_dat_s", d), m_dats_w[d], beef);
        end
        rst_n = 1'b1;

        // Single request, rty handling, ack+rty together
        add(1, 4'b0010, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b0010, 0, 0, 1,  1,  1, 0, 0);
        add(0, 4'b0010, 1, 0, 1,  1,  1, 1, 0);
        add(0, 4'b0000, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b0100, 0, 1, 0, -1, -1, 0, 0);
        add(0, 4'b0100, 0, 1, 1,  2,  2, 0, 1);
        add(0, 4'b0100, 1, 1, 0, -1, -1, 0, 0);
        add(0, 4'b0100, 1, 1, 1,  2,  2, 1, 0);
        add(0, 4'b0000, 0, 0, 0, -1, -1, 0, 0);
        // Full contention, slave acks in the second BUSY cycle
        for (int t = 0; t < 6; t++) begin
            add(t == 0, 4'b1111, 0, 0, 0, -1, -1, 0, 0);
            add(0, 4'b1111, 0, 0, 1, t % 4, 0, 0, 0);
            add(0, 4'b1111, 1, 0, 1, t % 4, 0, 1, 0);
        end
        // Ports 0 and 3: fixed priority serves 3 only once 0 lets go
        add(1, 4'b1001, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b1001, 0, 0, 1,  0,  0, 0, 0);
        add(0, 4'b1001, 1, 0, 1,  0,  0, 1, 0);
        add(0, 4'b1001, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b1001, 0, 0, 1,  3,  0, 0, 0);
        add(0, 4'b1001, 1, 0, 1,  3,  0, 1, 0);
        add(0, 4'b1000, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b1000, 0, 0, 1,  3,  3, 0, 0);
        add(0, 4'b1000, 1, 0, 1,  3,  3, 1, 0);
        // Abort: port 0 drops CYC in its second BUSY cycle
        add(1, 4'b0011, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b0011, 0, 0, 1,  0,  0, 0, 0);
        add(0, 4'b0010, 0, 0, 0,  0,  0, 0, 0);
        add(0, 4'b0010, 0, 0, 0, -1, -1, 0, 0);
        add(0, 4'b0010, 0, 0, 1,  1,  1, 0, 0);
        add(0, 4'b0010, 1, 0, 1,  1,  1, 1, 0);

        for (int r = 0; r < vt.size(); r++) begin
            @(posedge clk); #1;
            if (vt[r].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            m_cyc = vt[r].cyc;
            m_stb = vt[r].cyc;
            s_ack = vt[r].ack;
            s_rty = vt[r].rty;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int g;
                g = (d == 0) ? vt[r].g_rr : vt[r].g_fp;
                check($sformatf("tbl%0d.%0d s_cyc", r, d), s_cyc_w[d], vt[r].ecyc);
                check($sformatf("tbl%0d.%0d s_stb", r, d), s_stb_w[d], vt[r].ecyc);
                check($sformatf("tbl%0d.%0d m_ack", r, d), m_ack_w[d], vt[r].eack ? NP'(1 << g) : '0);
                check($sformatf("tbl%0d.%0d m_rty", r, d), m_rty_w[d], vt[r].erty ? NP'(1 << g) : '0);
                check($sformatf("tbl%0d.%0d m_dat_s", r, d), m_dats_w[d], beef);
                if (vt[r].ecyc)
                    check($sformatf("tbl%0d.%0d s_adr", r, d), s_adr_w[d], adr_tab[g]);
            end
        end

        // Asynchronous reset in the middle of a transfer
        @(posedge clk); #1;
        m_cyc = 4'b0100; m_stb = 4'b0100; s_ack = 1'b0; s_rty = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("arst.%0d busy s_cyc", d), s_cyc_w[d], 1'b1);
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("arst.%0d s_cyc", d), s_cyc_w[d], 1'b0);
            check($sformatf("arst.%0d s_stb", d), s_stb_w[d], 1'b0);
            check($sformatf("arst.%0d m_ack", d), m_ack_w[d], '0);
        end
        s_ack = 1'b0;
        m_cyc = 4'b1111; m_stb = 4'b1111;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            check($sformatf("arst.%0d idle s_cyc", d), s_cyc_w[d], 1'b0);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("arst.%0d first s_cyc", d), s_cyc_w[d], 1'b1);
            check($sformatf("arst.%0d first s_adr", d), s_adr_w[d], adr_tab[0]);
        end

        // Slave that never answers
        m_cyc = 4'b0010; m_stb = 4'b0010;
        pulse_reset();
`ifdef WB_ARB_TIMEOUT_EN
        @(posedge clk); #1;
        for (int c = 1; c <= TO + 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("tmo c%0d.%0d m_rty", c, d), m_rty_w[d],
                      (c == TO) ? 4'b0010 : 4'b0000);
                check($sformatf("tmo c%0d.%0d s_cyc", c, d), s_cyc_w[d], c != TO + 1);
            end
            @(posedge clk); #1;
        end
`else
        repeat (101) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("hang.%0d s_stb", d), s_stb_w[d], 1'b1);
            check($sformatf("hang.%0d m_rty", d), m_rty_w[d], '0);
        end
`endif

        // Randomised traffic against the reference model
        m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_rty = 1'b0;
        pulse_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 9) < 8);
                m_we[i] = 1'($urandom);
                m_adr[i*AW +: AW] = AW'($urandom);
                m_sel[i*SW +: SW] = SW'($urandom);
                m_dat_m[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            s_ack = ($urandom_range(0, 9) < 3);
            s_rty = ($urandom_range(0, 9) < 1);
            s_dat_s = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            model_check_step(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
